// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry, receiver FSM states and parity helper.
// Used by uart_rx and uart_tx.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_WORD_SIZE    = 8;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        IDLE   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_state_e;

    // Even-parity bit for a data word: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Flop-chain synchroniser for an asynchronous single-bit input.
// Reset value is a parameter so idle-high lines come out of reset inactive.
module uart_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data(LSB first)/stop framing into a host holding register.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int WORD_SIZE    = UART_WORD_SIZE,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 read_ack,
    output logic [WORD_SIZE-1:0] rcv_datareg,
    output logic                 byte_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 parity_error
);

    localparam int CW = $clog2(CLKS_PER_BIT + SYNC_STAGES + 1);
    localparam int BW = $clog2(WORD_SIZE + 1);

    localparam logic [CW-1:0] HALF_M1    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HUNT_GUARD = CW'(SYNC_STAGES);
    localparam logic [BW-1:0] LAST_BIT   = BW'(WORD_SIZE - 1);

    logic rx_s;

    uart_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (serial_in),
        .q_o (rx_s)
    );

    uart_state_e          state_q;
    logic [CW-1:0]        ccnt_q;
    logic [BW-1:0]        bcnt_q;
    logic [WORD_SIZE-1:0] shift_q;
    logic [WORD_SIZE-1:0] rcv_datareg_q;
    logic                 byte_ready_q;
    logic                 framing_error_q;
    logic                 overrun_error_q;

    logic bit_tick_d;
    logic complete_d;
    logic accept_d;
    logic frame_fe_d;
    logic frame_oe_d;

    assign bit_tick_d = (ccnt_q == FULL_M1);
    assign complete_d = (state_q == STOP) && bit_tick_d;
    assign accept_d   = complete_d && (!byte_ready_q || read_ack);
    assign frame_fe_d = complete_d && !rx_s;
    assign frame_oe_d = complete_d && byte_ready_q && !read_ack;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q;
    logic parity_error_q;
    logic frame_pe_d;

    assign frame_pe_d = complete_d && par_bad_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= HUNT;
            ccnt_q          <= '0;
            bcnt_q          <= '0;
            shift_q         <= '0;
            rcv_datareg_q   <= '0;
            byte_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q       <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                // The synchroniser resets to idle-high, so its contents are only trusted
                // once it has been refilled from the real line.
                HUNT: begin
                    if (ccnt_q != HUNT_GUARD) begin
                        ccnt_q <= ccnt_q + CW'(1);
                    end else if (rx_s) begin
                        state_q <= IDLE;
                        ccnt_q  <= '0;
                    end
                end
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        ccnt_q  <= '0;
                        bcnt_q  <= '0;
                    end
                end
                START: begin
                    if (ccnt_q == HALF_M1) begin
                        ccnt_q  <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        ccnt_q <= ccnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_tick_d) begin
                        ccnt_q  <= '0;
                        shift_q <= {rx_s, shift_q[WORD_SIZE-1:1]};
                        bcnt_q  <= bcnt_q + BW'(1);
                        if (bcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        ccnt_q <= ccnt_q + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_tick_d) begin
                        ccnt_q    <= '0;
                        par_bad_q <= (rx_s != even_parity(64'(shift_q)));
                        state_q   <= STOP;
                    end else begin
                        ccnt_q <= ccnt_q + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_tick_d) begin
                        ccnt_q  <= '0;
                        state_q <= rx_s ? IDLE : HUNT;
                    end else begin
                        ccnt_q <= ccnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= HUNT;
                    ccnt_q  <= '0;
                end
            endcase

            // Host side: a completing frame outranks a simultaneous acknowledge.
            if (accept_d) begin
                rcv_datareg_q <= shift_q;
            end
            if (complete_d) begin
                byte_ready_q <= 1'b1;
            end else if (read_ack) begin
                byte_ready_q <= 1'b0;
            end
            framing_error_q <= frame_fe_d | (framing_error_q & ~read_ack);
            overrun_error_q <= frame_oe_d | (overrun_error_q & ~read_ack);
`ifdef UART_RX_PARITY_EN
            parity_error_q  <= frame_pe_d | (parity_error_q & ~read_ack);
`endif
        end
    end

    assign rcv_datareg   = rcv_datareg_q;
    assign byte_ready    = byte_ready_q;
    assign framing_error = framing_error_q;
    assign overrun_error = overrun_error_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_error_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule
